// File: rtl/hyp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hyp_pkg
//  Brief    : Shared types and helpers for the logistic-regression hypothesis
//             engine: FSM state encoding, width helpers, z saturation.
//  Revision : 1.0 - initial release
// ============================================================================
package hyp_pkg;

    // Engine phases: wait for a sample, multiply-accumulate, activate, present.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2,
        OUT  = 2'd3
    } hyp_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: N full-width signed products can never overflow it.
    function automatic int accw(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction

    // Clamp a shifted accumulator to the signed dw-bit range.
    function automatic longint sat_clip(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -(longint'(1) << (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // High when sat_clip would change the value.
    function automatic logic sat_flag(input longint v, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) << (dw - 1)) - 1;
        lo = -(longint'(1) << (dw - 1));
        return (v > hi) || (v < lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigmoid_lut_param.sv
`default_nettype none
// ============================================================================
//  Module   : sigmoid_lut_param
//  Brief    : Registered sigmoid lookup. z is signed with ZFRAC fractional
//             bits; h is unsigned Q0.DW, rounded and clipped to 2^DW-1.
//             Table contents are computed at elaboration.
//  Revision : 1.0 - initial release
// ============================================================================
module sigmoid_lut_param #(
    parameter int DW    = 8,
    parameter int ZFRAC = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic signed [DW-1:0] z,
    output logic        [DW-1:0] h
);

    // exp(v) by halving the argument into [-0.5, 0.5], a Taylor series,
    // then squaring back up.
    function automatic real exp_approx(input real v);
        real r;
        real term;
        real sum;
        int  k;
        r = v;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (r > 0.5 || r < -0.5) begin
                r = r / 2.0;
                k = k + 1;
            end
        end
        sum  = 1.0;
        term = 1.0;
        for (int j = 1; j < 20; j++) begin
            term = term * r / real'(j);
            sum  = sum + term;
        end
        for (int i = 0; i < 16; i++) begin
            if (i < k) sum = sum * sum;
        end
        return sum;
    endfunction

    // Rounded sigmoid for one signed z code, clipped so 1.0 maps to all-ones.
    function automatic int lut_entry(input int zv);
        real v;
        real s;
        int  q;
        v = real'(zv) / real'(2 ** ZFRAC);
        s = 1.0 / (1.0 + exp_approx(-v));
        q = $rtoi(s * real'(2 ** DW) + 0.5);
        if (q > 2 ** DW - 1) q = 2 ** DW - 1;
        return q;
    endfunction

    logic [DW-1:0] w_lut [2**DW];
    logic [DW-1:0] w_idx;
    logic [DW-1:0] r_h;

    // Table is indexed by the two's-complement bit pattern of z.
    for (genvar i = 0; i < 2 ** DW; i++) begin : g_lut
        localparam int c_zv  = (i >= 2 ** (DW - 1)) ? i - 2 ** DW : i;
        localparam int c_val = lut_entry(c_zv);
        assign w_lut[i] = DW'(c_val);
    end

    assign w_idx = z;

    // Registered table read; holds while enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
        end else if (enable) begin
            r_h <= w_lut[w_idx];
        end
    end

    assign h = r_h;

endmodule
`default_nettype wire

// File: rtl/hypothesis_engine.sv
`default_nettype none
// ============================================================================
//  Module   : hypothesis_engine
//  Brief    : h = sigmoid(x . teta) for one N-element sample per transaction.
//             LANES signed products per cycle are accumulated over N/LANES
//             cycles, shifted, saturated to DW bits and looked up.
//  Revision : 1.0 - initial release
// ============================================================================
module hypothesis_engine
    import hyp_pkg::*;
#(
    parameter int DW     = 8,
    parameter int N      = 8,
    parameter int LANES  = 2,
    parameter int ZSHIFT = 8,
    parameter int ZFRAC  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*DW-1:0]   x,
    input  logic [N*DW-1:0]   teta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     h,
    output logic              z_sat
);

    localparam int c_accw  = accw(DW, N);
    localparam int c_steps = N / LANES;
    localparam int c_cntw  = (c_steps > 1) ? clog2(c_steps) : 1;
    localparam logic [c_cntw-1:0] c_last = c_cntw'(c_steps - 1);

    hyp_state_e                 r_state;
    logic [N*DW-1:0]            r_x;
    logic [N*DW-1:0]            r_teta;
    logic signed [c_accw-1:0]   r_acc;
    logic [c_cntw-1:0]          r_cnt;
    logic                       r_zsat;

    logic signed [2*DW-1:0]     w_prod [LANES];
    logic signed [c_accw-1:0]   w_lane_sum;
    logic signed [c_accw-1:0]   w_zt;
    logic signed [DW-1:0]       w_z;
    logic                       w_sat;
    logic                       w_lut_en;

    // The operand registers shift down by one lane group per MAC cycle, so
    // the lowest LANES elements are always the ones being multiplied.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [2*DW-1:0] w_a;
        logic signed [2*DW-1:0] w_b;
        assign w_a = {{DW{r_x[l*DW+DW-1]}}, r_x[l*DW +: DW]};
        assign w_b = {{DW{r_teta[l*DW+DW-1]}}, r_teta[l*DW +: DW]};
        assign w_prod[l] = w_a * w_b;
    end

    // Sum of this cycle's lane products, sign-extended to accumulator width.
    always_comb begin
        w_lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            w_lane_sum = w_lane_sum + c_accw'(w_prod[l]);
        end
    end

    assign w_zt     = r_acc >>> ZSHIFT;
    assign w_z      = DW'(sat_clip(longint'(w_zt), DW));
    assign w_sat    = sat_flag(longint'(w_zt), DW);
    assign w_lut_en = enable && (r_state == ACT);

    // Transaction sequencing and multiply-accumulate; enable low freezes all.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_teta  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_zsat  <= 1'b0;
        end else if (enable) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= x;
                        r_teta  <= teta;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc  <= r_acc + w_lane_sum;
                    r_x    <= r_x >> (LANES * DW);
                    r_teta <= r_teta >> (LANES * DW);
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == c_last) r_state <= ACT;
                end
                ACT: begin
                    r_zsat  <= w_sat;
                    r_state <= OUT;
                end
                OUT: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sigmoid_lut_param #(
        .DW    (DW),
        .ZFRAC (ZFRAC)
    ) u_lut (
        .clk    (clk),
        .reset  (reset),
        .enable (w_lut_en),
        .z      (w_z),
        .h      (h)
    );

    assign in_ready  = (r_state == IDLE) && enable;
    assign out_valid = (r_state == OUT);
    assign z_sat     = r_zsat;

endmodule
`default_nettype wire

// File: tb/tb_hypothesis_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hypothesis_engine
//  Brief    : Directed self-checking bench for hypothesis_engine with
//             LANES = 2 (main), 1 and 8 instances sharing data inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hypothesis_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        out_ready;
    logic [2:0]  iv;
    logic [63:0] x;
    logic [63:0] teta;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [2:0]  zs;
    logic [7:0]  h0;
    logic [7:0]  h1;
    logic [7:0]  h8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hypothesis_engine #(.DW(8), .N(8), .LANES(2), .ZSHIFT(8), .ZFRAC(4)) u_l2 (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(iv[0]), .in_ready(ir[0]), .x(x), .teta(teta),
        .out_valid(ov[0]), .out_ready(out_ready), .h(h0), .z_sat(zs[0])
    );

    hypothesis_engine #(.DW(8), .N(8), .LANES(1), .ZSHIFT(8), .ZFRAC(4)) u_l1 (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(iv[1]), .in_ready(ir[1]), .x(x), .teta(teta),
        .out_valid(ov[1]), .out_ready(out_ready), .h(h1), .z_sat(zs[1])
    );

    hypothesis_engine #(.DW(8), .N(8), .LANES(8), .ZSHIFT(8), .ZFRAC(4)) u_l8 (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(iv[2]), .in_ready(ir[2]), .x(x), .teta(teta),
        .out_valid(ov[2]), .out_ready(out_ready), .h(h8), .z_sat(zs[2])
    );

    function automatic logic [7:0] hsel(input int sel);
        return (sel == 0) ? h0 : (sel == 1) ? h1 : h8;
    endfunction

    // Present a uniform sample to one instance and hold it until accepted.
    task automatic send(input int sel, input logic [7:0] xv, input logic [7:0] tv,
                        output bit ok);
        x       = {8{xv}};
        teta    = {8{tv}};
        iv[sel] = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ir[sel]) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        iv[sel] = 1'b0;
    endtask

    // Edges from the accept edge (counted as 1) to the edge raising out_valid.
    task automatic wait_out(input int sel, output int lat);
        lat = 1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ov[sel]) return;
        end
        lat = 999;
    endtask

    task automatic run(input int sel, input logic [7:0] xv, input logic [7:0] tv,
                       output int lat);
        bit ok;
        send(sel, xv, tv, ok);
        if (!ok) lat = 998;
        else     wait_out(sel, lat);
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; out_ready = 1'b0; iv = '0;
        x = '0; teta = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", ir[0]); end
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", ov[0]); end
        total++; if (h0 !== 8'd0) begin bad++; $display("FAIL reset_h got=%0d exp=0", h0); end
        total++; if (zs[0] !== 1'b0) begin bad++; $display("FAIL reset_z_sat got=%b exp=0", zs[0]); end
    endtask

    task automatic test_zero();
        int lat;
        run(0, 8'd0, 8'd16, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL zero_latency got=%0d exp=6", lat); end
        total++; if (h0 !== 8'd128) begin bad++; $display("FAIL zero_h got=%0d exp=128", h0); end
        total++; if (zs[0] !== 1'b0) begin bad++; $display("FAIL zero_z_sat got=%b exp=0", zs[0]); end
        total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL zero_in_ready_busy got=%b exp=0", ir[0]); end
        pop();
    endtask

    task automatic test_mid();
        int lat;
        run(0, 8'd16, 8'd16, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL mid_latency got=%0d exp=6", lat); end
        total++; if (h0 !== 8'd159) begin bad++; $display("FAIL mid_h got=%0d exp=159", h0); end
        total++; if (zs[0] !== 1'b0) begin bad++; $display("FAIL mid_z_sat got=%b exp=0", zs[0]); end
        pop();
    endtask

    task automatic test_saturation();
        int lat;
        run(0, 8'd127, 8'd127, lat);
        total++; if (h0 !== 8'd255) begin bad++; $display("FAIL sat_pos_h got=%0d exp=255", h0); end
        total++; if (zs[0] !== 1'b1) begin bad++; $display("FAIL sat_pos_z_sat got=%b exp=1", zs[0]); end
        pop();
        run(0, 8'd127, 8'h80, lat);
        total++; if (h0 !== 8'd0) begin bad++; $display("FAIL sat_neg_h got=%0d exp=0", h0); end
        total++; if (zs[0] !== 1'b1) begin bad++; $display("FAIL sat_neg_z_sat got=%b exp=1", zs[0]); end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        run(0, 8'd16, 8'd16, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL bp_latency got=%0d exp=6", lat); end
        // Second sample waits while the first result is stuck.
        x = {8{8'd0}}; teta = {8{8'd16}}; iv[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, ov[0]); end
            total++; if (h0 !== 8'd159) begin bad++; $display("FAIL bp_h cyc=%0d got=%0d exp=159", c, h0); end
            total++; if (zs[0] !== 1'b0) begin bad++; $display("FAIL bp_z_sat cyc=%0d got=%b exp=0", c, zs[0]); end
            total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, ir[0]); end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (ir[0] !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b exp=1", ir[0]); end
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL bp_valid_after_pop got=%b exp=0", ov[0]); end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b exp=0", ir[0]); end
        wait_out(0, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL bp_second_latency got=%0d exp=6", lat); end
        total++; if (h0 !== 8'd128) begin bad++; $display("FAIL bp_second_h got=%0d exp=128", h0); end
        pop();
    endtask

    task automatic test_stall();
        bit ok;
        int lat;
        send(0, 8'd16, 8'd16, ok);
        lat = 1;
        @(posedge clk); #1; lat++;
        @(posedge clk); #1; lat++;
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk); #1; lat++;
            total++; if (ir[0] !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", ir[0]); end
        end
        enable = 1'b1;
        for (int i = 0; i < 60 && !ov[0]; i++) begin
            @(posedge clk); #1; lat++;
        end
        if (!ov[0] || !ok) lat = 999;
        total++; if (lat !== 11) begin bad++; $display("FAIL stall_latency got=%0d exp=11", lat); end
        total++; if (h0 !== 8'd159) begin bad++; $display("FAIL stall_h got=%0d exp=159", h0); end
        total++; if (zs[0] !== 1'b0) begin bad++; $display("FAIL stall_z_sat got=%b exp=0", zs[0]); end
        // Frozen in OUT: out_ready is not honoured while enable is low.
        enable = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (ov[0] !== 1'b1) begin bad++; $display("FAIL stall_out_hold got=%b exp=1", ov[0]); end
        total++; if (h0 !== 8'd159) begin bad++; $display("FAIL stall_out_h got=%0d exp=159", h0); end
        enable = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (ov[0] !== 1'b0) begin bad++; $display("FAIL stall_pop got=%b exp=0", ov[0]); end
    endtask

    task automatic test_reset_abort(input int sel, input int exp_lat, input int pre_edges);
        bit ok;
        int lat;
        send(sel, 8'd127, 8'd127, ok);
        repeat (pre_edges) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (ir[sel] !== 1'b1) begin bad++; $display("FAIL abort%0d_in_ready got=%b exp=1", sel, ir[sel]); end
        total++; if (ov[sel] !== 1'b0) begin bad++; $display("FAIL abort%0d_out_valid got=%b exp=0", sel, ov[sel]); end
        total++; if (hsel(sel) !== 8'd0) begin bad++; $display("FAIL abort%0d_h_reset got=%0d exp=0", sel, hsel(sel)); end
        run(sel, 8'd0, 8'd16, lat);
        total++; if (lat !== exp_lat) begin bad++; $display("FAIL abort%0d_latency got=%0d exp=%0d", sel, lat, exp_lat); end
        total++; if (hsel(sel) !== 8'd128) begin bad++; $display("FAIL abort%0d_h got=%0d exp=128", sel, hsel(sel)); end
        total++; if (zs[sel] !== 1'b0) begin bad++; $display("FAIL abort%0d_z_sat got=%b exp=0", sel, zs[sel]); end
        pop();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_mid();
        test_saturation();
        test_backpressure();
        test_stall();
        test_reset_abort(0, 6, 2);
        test_reset_abort(1, 10, 3);
        test_reset_abort(2, 3, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
